hazard_ctrl_unit: RTL
=====================

Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the single-branch hazard unit. Generates issue/fetch stalls, per-RS enables, per-FU exec stalls and writeback-slot enables for an arbitrary number of issue classes.
- Tracks up to MAX_BR unresolved branches with a counter, replacing the old single in-exec flag.
- Adds a fetch-starvation guard so that a continuous stream of load-buffer memory reads cannot lock out instruction fetch indefinitely.
- Sits between the IF/IS stage, the reservation stations, the FU output registers and the memory arbiter.

Parameters:
- NUM_RS, 3, number of issue classes; class i has RS i, FU i and writeback register i.
- LD_RS, 0, class index of the load/store RS (ACU path).
- BR_RS, 1, class index that executes branches.
- MAX_BR, 2, maximum unresolved branches in flight. MAX_BR=1 reproduces single-branch behaviour.
- STARVE_LIMIT, 4, consecutive cycles of fetch blocked by load reads before fetch is forced through; range 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- rs_full  in  NUM_RS  per-RS full
- rob_full  in  1  ROB full
- lb_full  in  1  load buffer full
- is_valid_inst  in  1  IS-stage instruction valid
- is_class  in  NUM_RS  one-hot issue class of the IS instruction
- is_branch  in  1  IS instruction is a branch
- br_resolve  in  1  BR_RS FU holds a resolving branch this cycle
- branch_misprediction  in  1  flush request from commit
- commit_wr_mem  in  1  commit store uses memory this cycle
- lb_read_mem  in  1  load buffer requests memory
- Dmem_wait  in  1  data memory busy
- wb_valid  in  NUM_RS  FU output register holds a result
- wb_written  in  NUM_RS  that result is consumed by the CDB this cycle
- acu_wr_mem  in  1  ACU result is a store
- acu_rd_mem  in  1  ACU result is a load
- if_mem_hazard  out  1  fetch loses memory this cycle
- if_enable  out  1  PC/IF advance
- if_is_enable  out  1  IF/IS register load
- if_is_flush  out  1  IF/IS register clear
- rob_enable  out  1  ROB allocate
- rs_enable  out  NUM_RS  per-RS dispatch
- rs_exec_stall  out  NUM_RS  per-RS issue-to-FU stall
- wb_enable  out  NUM_RS  FU output register may load
- lb_exec_stall  out  1  load buffer must not access memory
- br_count  out  $clog2(MAX_BR+1)  unresolved branches
- br_full  out  1  br_count == MAX_BR
- starve_grant  out  1  forced-fetch cycle active

Behaviour:
- Reset values: br_count=0, br_full=0, starve counter=0, starve_grant=0. All combinational outputs follow from these.
- class_err = is_valid_inst & (is_class not one-hot). It is treated as a stall, never a dispatch.
- is_stall = rob_full | |(is_class & rs_full) | (is_branch & br_full) | class_err.
- is_enable = ~is_stall & is_valid_inst & ~branch_misprediction.
- rs_enable[i] = is_enable & is_class[i].
- rob_enable = is_enable.
- wb_enable[i] = ~wb_valid[i] | wb_written[i].
- rs_exec_stall[i] = ~wb_enable[i] for every i except LD_RS.
- rs_exec_stall[LD_RS] = (acu_wr_mem & ~wb_enable[LD_RS]) | (acu_rd_mem & lb_full).
- Memory hazard terms:
  - lb_hit = lb_read_mem & ~Dmem_wait & ~starve_grant.
  - if_mem_hazard = commit_wr_mem | lb_hit.
  - lb_exec_stall = commit_wr_mem | ~wb_enable[LD_RS] | Dmem_wait | starve_grant.
- Fetch/IS control:
  - if_enable = ~(if_mem_hazard | is_stall).
  - if_is_enable = ~is_stall.
  - if_is_flush = branch_misprediction | (if_mem_hazard & ~is_stall).
- Branch counter, registered, one update per cycle:
  - inc = is_branch & rs_enable[BR_RS].
  - dec = br_resolve & ~rs_exec_stall[BR_RS]. A branch held by an exec stall is counted once only.
  - branch_misprediction has priority and sets br_count to 0, ignoring inc and dec.
  - Otherwise inc&dec leaves the count unchanged, inc adds 1, dec subtracts 1.
  - dec at 0 and inc at MAX_BR cannot occur. Both saturate, and a simulation assertion fires.
  - br_full is registered alongside br_count, so it takes effect in the next cycle.
- Starvation guard, registered:
  - The counter increments on cycles where lb_hit=1, commit_wr_mem=0 and is_stall=0.
  - Any cycle without an lb-only hazard clears the counter.
  - When the counter reaches STARVE_LIMIT, starve_grant is set to 1 for exactly one cycle and the counter clears. During that cycle the load buffer is held and fetch proceeds.
  - commit_wr_mem always wins over the grant: if_mem_hazard stays 1, and the grant is consumed anyway.
- Reset asserted mid-operation clears the branch count and starvation state in the same edge. No partial state survives.

Decomposition:
- Package hazard_pkg holds:
  - the BR_CNT_W width function $clog2(MAX_BR+1);
  - STARVE_W=4;
  - default class index constants LD_CLASS=0, ALU_CLASS=1, MULT_CLASS=2.
- Sub-module branch_tracker (inc/dec/flush saturating counter plus full flag) is instantiated once.
- The starvation counter stays inline.

Test Plan:
- Branch limit: MAX_BR=2, dispatch 3 branches on consecutive cycles -> br_count goes 1, 2; third branch stalls (rs_enable=0, if_enable=0) until a br_resolve with wb_enable[BR_RS]=1.
- Held resolve: resolve with wb_valid[BR_RS]=1, wb_written=0 held for 3 cycles, then written -> br_count decrements once, on the written cycle.
- Simultaneous events: inc and dec in the same cycle at br_count=1 -> stays 1. Misprediction together with inc -> 0, rs_enable=0, if_is_flush=1.
- Starvation: STARVE_LIMIT=4, lb_read_mem=1, Dmem_wait=0 held continuously -> if_mem_hazard=1 for 4 cycles, then one cycle with starve_grant=1, if_mem_hazard=0, lb_exec_stall=1; the pattern repeats.
- Load path: acu_rd_mem=1 with lb_full=1 -> rs_exec_stall[LD_RS]=1 while other classes are unaffected. A bad is_class=3'b011 with valid=1 -> no dispatch, if_is_enable=0.
- Reset: assert reset with br_count=2 and the starve counter at 3 -> next cycle br_count=0, starve_grant=0, all enables follow the reset-state equations.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard control unit and its branch tracker.
package hazard_pkg;

   localparam int STARVE_W   = 4;
   localparam int LD_CLASS   = 0;
   localparam int ALU_CLASS  = 1;
   localparam int MULT_CLASS = 2;

   // Width needed to hold 0..max_br unresolved branches.
   function automatic int br_cnt_w(input int max_br);
      return $clog2(max_br + 1);
   endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle of pipeline-side signals seen by the hazard control unit.
// master: pipeline/memory side, slave: the hazard unit itself.
interface hazard_ctrl_if #(
   parameter int NUM_RS = 3,
   parameter int MAX_BR = 2
);
   import hazard_pkg::*;

   localparam int BR_W = br_cnt_w(MAX_BR);

   logic [NUM_RS-1:0] rs_full;
   logic              rob_full;
   logic              lb_full;
   logic              is_valid_inst;
   logic [NUM_RS-1:0] is_class;
   logic              is_branch;
   logic              br_resolve;
   logic              branch_misprediction;
   logic              commit_wr_mem;
   logic              lb_read_mem;
   logic              Dmem_wait;
   logic [NUM_RS-1:0] wb_valid;
   logic [NUM_RS-1:0] wb_written;
   logic              acu_wr_mem;
   logic              acu_rd_mem;

   logic              if_mem_hazard;
   logic              if_enable;
   logic              if_is_enable;
   logic              if_is_flush;
   logic              rob_enable;
   logic [NUM_RS-1:0] rs_enable;
   logic [NUM_RS-1:0] rs_exec_stall;
   logic [NUM_RS-1:0] wb_enable;
   logic              lb_exec_stall;
   logic [BR_W-1:0]   br_count;
   logic              br_full;
   logic              starve_grant;

   modport master (
      output rs_full, rob_full, lb_full, is_valid_inst, is_class, is_branch,
             br_resolve, branch_misprediction, commit_wr_mem, lb_read_mem,
             Dmem_wait, wb_valid, wb_written, acu_wr_mem, acu_rd_mem,
      input  if_mem_hazard, if_enable, if_is_enable, if_is_flush, rob_enable,
             rs_enable, rs_exec_stall, wb_enable, lb_exec_stall, br_count,
             br_full, starve_grant
   );

   modport slave (
      input  rs_full, rob_full, lb_full, is_valid_inst, is_class, is_branch,
             br_resolve, branch_misprediction, commit_wr_mem, lb_read_mem,
             Dmem_wait, wb_valid, wb_written, acu_wr_mem, acu_rd_mem,
      output if_mem_hazard, if_enable, if_is_enable, if_is_flush, rob_enable,
             rs_enable, rs_exec_stall, wb_enable, lb_exec_stall, br_count,
             br_full, starve_grant
   );

endinterface

// File: rtl/hazard_ctrl_unit_branch_tracker.sv
// Counts unresolved branches in flight; flush clears, inc/dec saturate.
module branch_tracker #(
   parameter int MAX_BR = 2,
   parameter int CNT_W  = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   input  logic             flush,
   output logic [CNT_W-1:0] br_count,
   output logic             br_full
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BR);

   logic [CNT_W-1:0] br_count_d, br_count_q;
   logic             br_full_d, br_full_q;

   // Next count: flush wins, simultaneous inc/dec cancel, ends saturate.
   always_comb begin
      br_count_d = br_count_q;
      if (flush) begin
         br_count_d = '0;
      end else if (inc && !dec) begin
         if (br_count_q != CNT_MAX) br_count_d = br_count_q + 1'b1;
      end else if (dec && !inc) begin
         if (br_count_q != '0) br_count_d = br_count_q - 1'b1;
      end
      br_full_d = (br_count_d == CNT_MAX);
   end

   // Count and full flag register together so the stall lands next cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         br_count_q <= '0;
         br_full_q  <= 1'b0;
      end else begin
         br_count_q <= br_count_d;
         br_full_q  <= br_full_d;
      end
   end

   assign br_count = br_count_q;
   assign br_full  = br_full_q;

   // The dispatch stall on br_full and the resolve rules should make these unreachable.
   a_no_overflow : assert property (@(posedge clock) disable iff (reset)
      !(inc && !dec && !flush && br_count_q == CNT_MAX));
   a_no_underflow : assert property (@(posedge clock) disable iff (reset)
      !(dec && !inc && !flush && br_count_q == '0));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/enable generation for IF/IS, reservation stations, FU writeback
// registers and the load buffer, with multi-branch tracking and a guard
// that stops load-buffer reads from starving instruction fetch.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int NUM_RS       = 3,
   parameter int LD_RS        = LD_CLASS,
   parameter int BR_RS        = ALU_CLASS,
   parameter int MAX_BR       = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clock,
   input  logic          reset,
   hazard_ctrl_if.slave  hif
);

   localparam int BR_W = br_cnt_w(MAX_BR);

   logic              class_err;
   logic              is_stall;
   logic              is_enable;
   logic [NUM_RS-1:0] rs_en;
   logic [NUM_RS-1:0] wb_en;
   logic [NUM_RS-1:0] exec_stall;
   logic              lb_hit;
   logic              mem_hazard;
   logic              lb_only;
   logic              br_inc;
   logic              br_dec;
   logic [BR_W-1:0]   br_count;
   logic              br_full;

   logic [STARVE_W-1:0] starve_cnt_d, starve_cnt_q;
   logic                starve_grant_d, starve_grant_q;

   // Issue-side stall: a malformed class is treated as a stall, never a dispatch.
   always_comb begin
      class_err = hif.is_valid_inst & ~$onehot(hif.is_class);
      is_stall  = hif.rob_full | (|(hif.is_class & hif.rs_full))
                | (hif.is_branch & br_full) | class_err;
      is_enable = ~is_stall & hif.is_valid_inst & ~hif.branch_misprediction;
      rs_en     = {NUM_RS{is_enable}} & hif.is_class;
   end

   // FU output registers and issue-to-FU stalls; the load class also waits on the LB.
   always_comb begin
      wb_en             = ~hif.wb_valid | hif.wb_written;
      exec_stall        = ~wb_en;
      exec_stall[LD_RS] = (hif.acu_wr_mem & ~wb_en[LD_RS]) | (hif.acu_rd_mem & hif.lb_full);
   end

   // Memory port arbitration between fetch, committing stores and load reads.
   always_comb begin
      lb_hit     = hif.lb_read_mem & ~hif.Dmem_wait & ~starve_grant_q;
      mem_hazard = hif.commit_wr_mem | lb_hit;
      lb_only    = lb_hit & ~hif.commit_wr_mem & ~is_stall;
   end

   // A branch held in exec by a busy writeback register is only counted on release.
   always_comb begin
      br_inc = hif.is_branch & rs_en[BR_RS];
      br_dec = hif.br_resolve & ~exec_stall[BR_RS];
   end

   branch_tracker #(
      .MAX_BR (MAX_BR),
      .CNT_W  (BR_W)
   ) u_branch_tracker (
      .clock    (clock),
      .reset    (reset),
      .inc      (br_inc),
      .dec      (br_dec),
      .flush    (hif.branch_misprediction),
      .br_count (br_count),
      .br_full  (br_full)
   );

   // Run length of lb-only fetch blocks; at the limit, grant fetch one cycle and restart.
   always_comb begin
      starve_cnt_d   = '0;
      starve_grant_d = 1'b0;
      if (!starve_grant_q && lb_only) begin
         if (starve_cnt_q == STARVE_W'(STARVE_LIMIT - 1)) starve_grant_d = 1'b1;
         else starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   // Starvation guard state.
   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt_q   <= '0;
         starve_grant_q <= 1'b0;
      end else begin
         starve_cnt_q   <= starve_cnt_d;
         starve_grant_q <= starve_grant_d;
      end
   end

   assign hif.if_mem_hazard = mem_hazard;
   assign hif.if_enable     = ~(mem_hazard | is_stall);
   assign hif.if_is_enable  = ~is_stall;
   assign hif.if_is_flush   = hif.branch_misprediction | (mem_hazard & ~is_stall);
   assign hif.rob_enable    = is_enable;
   assign hif.rs_enable     = rs_en;
   assign hif.rs_exec_stall = exec_stall;
   assign hif.wb_enable     = wb_en;
   assign hif.lb_exec_stall = hif.commit_wr_mem | ~wb_en[LD_RS] | hif.Dmem_wait | starve_grant_q;
   assign hif.br_count      = br_count;
   assign hif.br_full       = br_full;
   assign hif.starve_grant  = starve_grant_q;

endmodule
